// File: rtl/mo_linebuf.sv
// rtl/mo_linebuf.sv - double-buffered motion-object line buffer
//
// Two 256 x PIX_W banks. The front bank is read at the beam position and
// cleared behind it; the sprite engine writes the back bank for the next line.
// The banks swap on the 256H rising edge, which is the start of horizontal blank.
//
// Ports:
//   clk        - 12 MHz master clock (same clock as the H counter)
//   reset_n    - asynchronous active-low reset
//   h          - H count [9:0]: h[0] = 6 MHz phase, h[8:1] = beam X, h[9] = 256H
//   vblank     - vertical blank; forces the displayed pixel to 0
//   wr_valid   - sprite engine write request
//   wr_x       - target X in the back bank
//   wr_pix     - pixel value (0 = transparent)
//   wr_ready   - high while a write can be accepted
//   line_start - one-clk pulse after each bank swap
//   mo_pix     - registered pixel for the current beam position
module mo_linebuf #(
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [9:0]       h,
    input  logic             vblank,
    input  logic             wr_valid,
    input  logic [7:0]       wr_x,
    input  logic [PIX_W-1:0] wr_pix,
    output logic             wr_ready,
    output logic             line_start,
    output logic [PIX_W-1:0] mo_pix
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    state_t           state_q;
    logic [7:0]       init_addr_q;
    logic             bank_sel_q;
    logic             h9_q;
    logic             wr_ready_q;
    logic             line_start_q;
    logic [PIX_W-1:0] mo_pix_q;
    logic [7:0]       wx_q;
    logic [PIX_W-1:0] wp_q;
    logic             wb_q;

    logic [PIX_W-1:0] bank0_q [256];
    logic [PIX_W-1:0] bank1_q [256];

    logic             swap_evt;
    logic [7:0]       beam_x;
    logic [PIX_W-1:0] front_pix;
    logic [PIX_W-1:0] latched_pix;
    logic             check_wr;
    logic             clear_en;

    logic             we0_d, we1_d;
    logic [7:0]       wa0_d, wa1_d;
    logic [PIX_W-1:0] wd0_d, wd1_d;

    assign swap_evt    = h[9] & ~h9_q;
    assign beam_x      = h[8:1];
    assign front_pix   = bank_sel_q ? bank1_q[beam_x] : bank0_q[beam_x];
    assign latched_pix = wb_q ? bank1_q[wx_q] : bank0_q[wx_q];

    // First non-transparent writer wins: only fill an empty location.
    assign check_wr = (state_q == ST_CHECK) && (wp_q != '0) && (latched_pix == '0);
    // Clear on the second half of each pixel, after it has been read out.
    assign clear_en = (state_q != ST_INIT) && !h[9] && h[0];

    // Per-bank write port. The clear always targets the front bank and the
    // sprite write targets the bank latched at acceptance; they cannot collide
    // because clears stop during blank, when a latched bank may become front.
    always_comb begin
        we0_d = 1'b0;
        wa0_d = '0;
        wd0_d = '0;
        we1_d = 1'b0;
        wa1_d = '0;
        wd1_d = '0;
        if (state_q == ST_INIT) begin
            we0_d = 1'b1;
            wa0_d = init_addr_q;
            we1_d = 1'b1;
            wa1_d = init_addr_q;
        end else begin
            if (check_wr && !wb_q) begin
                we0_d = 1'b1;
                wa0_d = wx_q;
                wd0_d = wp_q;
            end else if (clear_en && !bank_sel_q) begin
                we0_d = 1'b1;
                wa0_d = beam_x;
            end
            if (check_wr && wb_q) begin
                we1_d = 1'b1;
                wa1_d = wx_q;
                wd1_d = wp_q;
            end else if (clear_en && bank_sel_q) begin
                we1_d = 1'b1;
                wa1_d = beam_x;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we0_d) begin
            bank0_q[wa0_d] <= wd0_d;
        end
        if (we1_d) begin
            bank1_q[wa1_d] <= wd1_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_INIT;
            init_addr_q  <= '0;
            bank_sel_q   <= 1'b0;
            h9_q         <= 1'b0;
            wr_ready_q   <= 1'b0;
            line_start_q <= 1'b0;
            mo_pix_q     <= '0;
            wx_q         <= '0;
            wp_q         <= '0;
            wb_q         <= 1'b0;
        end else begin
            h9_q         <= h[9];
            line_start_q <= 1'b0;
            if (state_q == ST_INIT) begin
                mo_pix_q    <= '0;
                init_addr_q <= init_addr_q + 8'd1;
                if (init_addr_q == 8'hFF) begin
                    state_q    <= ST_IDLE;
                    wr_ready_q <= 1'b1;
                end
            end else begin
                if (swap_evt) begin
                    bank_sel_q   <= ~bank_sel_q;
                    line_start_q <= 1'b1;
                end
                if (h[9]) begin
                    mo_pix_q <= '0;
                end else if (!h[0]) begin
                    mo_pix_q <= vblank ? '0 : front_pix;
                end
                case (state_q)
                    ST_IDLE: begin
                        if (wr_valid) begin
                            wx_q       <= wr_x;
                            wp_q       <= wr_pix;
                            // Back bank as seen on this edge, before any swap.
                            wb_q       <= ~bank_sel_q;
                            state_q    <= ST_CHECK;
                            wr_ready_q <= 1'b0;
                        end
                    end
                    ST_CHECK: begin
                        state_q    <= ST_IDLE;
                        wr_ready_q <= 1'b1;
                    end
                    default: begin
                        state_q <= ST_INIT;
                    end
                endcase
            end
        end
    end

    assign wr_ready   = wr_ready_q;
    assign line_start = line_start_q;
    assign mo_pix     = mo_pix_q;

endmodule

// File: tb/tb_mo_linebuf.sv
// tb/tb_mo_linebuf.sv - randomized bench for mo_linebuf against a line-array model
module tb_mo_linebuf;

    logic       clk;
    logic       reset_n;
    logic [9:0] h;
    logic       vblank;
    logic       wr_valid;
    logic [7:0] wr_x;
    logic [7:0] wr_pix;
    logic       wr_ready;
    logic       line_start;
    logic [7:0] mo_pix;

    mo_linebuf #(.PIX_W(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .h          (h),
        .vblank     (vblank),
        .wr_valid   (wr_valid),
        .wr_x       (wr_x),
        .wr_pix     (wr_pix),
        .wr_ready   (wr_ready),
        .line_start (line_start),
        .mo_pix     (mo_pix)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] x;
        logic [7:0] p;
        int         at_h;
    } wr_t;

    wr_t wq[$];

    int n_vec;
    int n_err;
    int h_cnt;
    bit rnd_mode;
    logic [9:0] h_pre;
    int unsigned seen [256];

    // Reference model: two line arrays, a display index, INIT countdown.
    int unsigned mem [2][256];
    int          front;
    int          init_left;
    bit          m_h9;
    bit          exp_ready;
    bit          exp_ls;
    int unsigned exp_mo;
    bit          accepted;

    task automatic check_val(input string tag, input int unsigned act, input int unsigned exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at h=%0h t=%0t", tag, act, exp, h_pre, $time);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 256; a++)
                mem[b][a] = 0;
        front     = 0;
        init_left = 256;
        m_h9      = 1'b0;
        exp_ready = 1'b0;
        exp_ls    = 1'b0;
        exp_mo    = 0;
        accepted  = 1'b0;
    endtask

    // Predicts the effect of the coming rising edge from the current inputs.
    task automatic model_edge();
        bit acc;
        bit sw;
        if (!reset_n) begin
            model_reset();
            return;
        end
        acc  = wr_valid && exp_ready;
        sw   = h[9] && !m_h9;
        m_h9 = h[9];
        if (init_left > 0) begin
            init_left--;
            exp_mo    = 0;
            exp_ls    = 1'b0;
            exp_ready = (init_left == 0);
        end else begin
            exp_ls = sw;
            if (h[9])
                exp_mo = 0;
            else if (!h[0])
                exp_mo = vblank ? 0 : mem[front][h[8:1]];
            else
                mem[front][h[8:1]] = 0;
            if (acc) begin
                if (wr_pix != 0 && mem[1 - front][wr_x] == 0)
                    mem[1 - front][wr_x] = wr_pix;
                exp_ready = 1'b0;
            end else begin
                exp_ready = 1'b1;
            end
            if (sw)
                front = 1 - front;
        end
        accepted = acc;
    endtask

    task automatic drive_wr();
        if (wq.size() > 0 && (wq[0].at_h < 0 || wq[0].at_h == int'(h)) &&
            !(rnd_mode && $urandom_range(0, 3) == 0)) begin
            wr_valid = 1'b1;
            wr_x     = wq[0].x;
            wr_pix   = wq[0].p;
        end else begin
            wr_valid = 1'b0;
            wr_x     = 8'($urandom);
            wr_pix   = 8'($urandom);
        end
    endtask

    // One clock: model the edge, advance H and the write driver, then compare
    // outputs on the falling edge.
    task automatic tick();
        model_edge();
        h_pre = h;
        @(posedge clk);
        #1;
        if (accepted)
            void'(wq.pop_front());
        h_cnt = (h_cnt == 767) ? 0 : h_cnt + 1;
        h     = h_cnt[9:0];
        drive_wr();
        @(negedge clk);
        check_val("wr_ready", wr_ready, exp_ready);
        check_val("line_start", line_start, exp_ls);
        check_val("mo_pix", mo_pix, exp_mo);
        if (!h_pre[9] && !h_pre[0])
            seen[h_pre[8:1]] = mo_pix;
    endtask

    task automatic run_until_swap();
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!exp_ls && n < 2000);
        check_val("swap_seen", exp_ls, 1);
    endtask

    task automatic clear_seen();
        for (int i = 0; i < 256; i++)
            seen[i] = 32'hFFFF_FFFF;
    endtask

    function automatic int nz_count();
        int c;
        c = 0;
        for (int i = 0; i < 256; i++)
            if (seen[i] != 0)
                c++;
        return c;
    endfunction

    task automatic enq(input logic [7:0] x, input logic [7:0] p, input int at_h);
        wr_t e;
        e.x = x;
        e.p = p;
        e.at_h = at_h;
        wq.push_back(e);
    endtask

    task automatic do_reset(input int hold);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_val("rst_wr_ready", wr_ready, 0);
        check_val("rst_line_start", line_start, 0);
        check_val("rst_mo_pix", mo_pix, 0);
        repeat (hold) tick();
        reset_n = 1'b1;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        h_cnt    = 0;
        h        = 10'd0;
        h_pre    = 10'd0;
        vblank   = 1'b0;
        wr_valid = 1'b0;
        wr_x     = 8'd0;
        wr_pix   = 8'd0;
        rnd_mode = 1'b0;
        reset_n  = 1'b0;
        clear_seen();
        model_reset();
        @(negedge clk);
        do_reset(4);

        // INIT then the first swap; the bench line before it must be blank.
        run_until_swap();

        // Basic writes, priority and transparent writes.
        enq(8'h10, 8'h5A, -1);
        enq(8'hFF, 8'h01, -1);
        enq(8'h20, 8'h33, -1);
        enq(8'h20, 8'h77, -1);
        enq(8'h21, 8'h00, -1);
        run_until_swap();
        clear_seen();
        run_until_swap();
        check_val("px_10", seen[8'h10], 32'h5A);
        check_val("px_ff", seen[8'hFF], 32'h01);
        check_val("px_20_first_wins", seen[8'h20], 32'h33);
        check_val("px_21_transparent", seen[8'h21], 0);
        check_val("px_11_empty", seen[8'h11], 0);

        // The displayed bank was cleared behind the beam.
        run_until_swap();
        clear_seen();
        run_until_swap();
        check_val("cleared_line_nz", nz_count(), 0);

        // Accept a write on the edge just before the swap: CHECK on the swap clk.
        enq(8'h40, 8'h99, 10'h1FF);
        run_until_swap();
        check_val("swapchk_drained", wq.size(), 0);
        clear_seen();
        run_until_swap();
        check_val("px_40_swapchk", seen[8'h40], 32'h99);

        // vblank hides data; the line written during the last vblank line shows once.
        vblank = 1'b1;
        enq(8'h50, 8'h11, -1);
        run_until_swap();
        enq(8'h60, 8'h22, -1);
        clear_seen();
        run_until_swap();
        check_val("vblank_line_nz", nz_count(), 0);
        vblank = 1'b0;
        clear_seen();
        run_until_swap();
        check_val("px_60_after_vb", seen[8'h60], 32'h22);
        check_val("px_50_dropped", seen[8'h50], 0);
        clear_seen();
        run_until_swap();
        check_val("stale1_nz", nz_count(), 0);
        clear_seen();
        run_until_swap();
        check_val("stale2_nz", nz_count(), 0);

        // Randomized lines with a mid-line reset.
        rnd_mode = 1'b1;
        for (int ln = 0; ln < 8; ln++) begin
            vblank = ($urandom_range(0, 3) == 0);
            for (int k = 0; k < int'($urandom_range(10, 60)); k++)
                enq(8'($urandom), ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom), -1);
            if (ln == 4) begin
                repeat (int'($urandom_range(300, 600))) tick();
                do_reset(int'($urandom_range(1, 5)));
            end
            run_until_swap();
        end
        wq.delete();
        run_until_swap();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
